// File: rtl/conv_pe_sequencer_pkg.sv
// Shared constants for the Conv-layer PE sequencer: fp16 words and FSM encodings.
package conv_pe_sequencer_pkg;

  localparam int DATA_WIDTH = 16;

  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_FEED    = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/conv_pe_sequencer.sv
// Initiator for one fp16 MAC PE: latches a window/kernel, clears the PE,
// streams N operand pairs, then holds the captured dot product on valid/ready.
module conv_pe_sequencer
  import conv_pe_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              start,
  output logic                                              in_ready,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]     window,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]     kernel,
  output logic [DATA_WIDTH-1:0]                             pe_floatA,
  output logic [DATA_WIDTH-1:0]                             pe_floatB,
  output logic                                              pe_clear,
  input  logic [DATA_WIDTH-1:0]                             pe_result,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [DATA_WIDTH-1:0]                             out_data
);

  localparam int N = KERNEL_SIZE * KERNEL_SIZE;
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(N - 1);

  logic [2:0]                       state_q, state_d;
  logic [CNT_WIDTH-1:0]             idx_q, idx_d;
  logic [N-1:0][DATA_WIDTH-1:0]     win_q, ker_q;
  logic [DATA_WIDTH-1:0]            op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0]            op_b_q, op_b_d;
  logic                             clear_q;
  logic                             valid_q;
  logic [DATA_WIDTH-1:0]            data_q, data_d;
  logic                             accept;

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_ready && start;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_CLEAR;
      ST_CLEAR: begin
        state_d = ST_FEED;
        idx_d   = '0;
      end
      ST_FEED: begin
        if (idx_q == LAST_IDX) state_d = ST_CAPTURE;
        else                   idx_d   = idx_q + 1'b1;
      end
      ST_CAPTURE: begin
        // The last product was accumulated on the edge that entered CAPTURE.
        state_d = ST_DONE;
        data_d  = pe_result;
      end
      ST_DONE:    if (out_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Operands are registered from next-state so they line up with FEED cycles;
  // zero elsewhere keeps the free-running PE accumulator unchanged.
  always_comb begin
    op_a_d = '0;
    op_b_d = '0;
    if (state_d == ST_FEED) begin
      for (int i = 0; i < N; i++) begin
        if (idx_d == CNT_WIDTH'(i)) begin
          op_a_d = win_q[i];
          op_b_d = ker_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      win_q   <= '0;
      ker_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      clear_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        win_q <= window;
        ker_q <= kernel;
      end
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      clear_q <= (state_d == ST_CLEAR);
      valid_q <= (state_d == ST_DONE);
      data_q  <= data_d;
    end
  end

  assign pe_floatA = op_a_q;
  assign pe_floatB = op_b_q;
  assign pe_clear  = clear_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_conv_pe_sequencer.sv
// Bench for conv_pe_sequencer with a behavioural fp16 MAC PE and a cycle schedule model.
module tb_conv_pe_sequencer;

  localparam int DW = 16;
  localparam int KS = 3;
  localparam int N  = KS * KS;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              out_ready = 1'b0;
  logic [N*DW-1:0]   window = '0;
  logic [N*DW-1:0]   kernel = '0;
  logic              in_ready;
  logic [DW-1:0]     pe_floatA, pe_floatB, pe_result, out_data;
  logic              pe_clear, out_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  conv_pe_sequencer #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_ready(in_ready),
    .window(window), .kernel(kernel),
    .pe_floatA(pe_floatA), .pe_floatB(pe_floatB), .pe_clear(pe_clear),
    .pe_result(pe_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // Exact fp16 encoding of a non-negative integer below 2048.
  function automatic logic [15:0] to_fp16(input int n);
    int e;
    int mant;
    if (n <= 0) return 16'h0000;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    mant = ((n << 10) >> e) & 10'h3FF;
    return {1'b0, 5'(e + 15), 10'(mant)};
  endfunction

  function automatic real fp16_val(input logic [15:0] h);
    int  e;
    real m;
    if (h[14:10] == 5'd0) return 0.0;
    m = 1.0 + real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]) - 15;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    if (h[15]) m = -m;
    return m;
  endfunction

  // Free-running PE: accumulates every cycle, cleared by reset or pe_clear.
  real acc;
  always @(posedge clk or posedge reset) begin
    if (reset || pe_clear) acc <= 0.0;
    else                   acc <= acc + fp16_val(pe_floatA) * fp16_val(pe_floatB);
  end
  assign pe_result = to_fp16($rtoi(acc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"},   in_ready,  1);
    chk({tag, "_A"},     pe_floatA, 0);
    chk({tag, "_B"},     pe_floatB, 0);
    chk({tag, "_clr"},   pe_clear,  0);
    chk({tag, "_vld"},   out_valid, 0);
    chk({tag, "_data"},  out_data,  0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_job(input int wv[N], input int kv[N], input logic [15:0] exp_data,
                         input int hold, input bit scramble, input int rst_k);
    logic [N*DW-1:0] wp, kp;
    for (int i = 0; i < N; i++) begin
      wp[i*DW +: DW] = to_fp16(wv[i]);
      kp[i*DW +: DW] = to_fp16(kv[i]);
    end
    chk("idle_rdy", in_ready, 1);
    window = wp;
    kernel = kp;
    start  = 1'b1;
    @(negedge clk);
    start     = 1'($urandom);
    out_ready = 1'($urandom);
    chk("clr_pulse", pe_clear, 1);
    chk("clr_A", pe_floatA, 0);
    chk("clr_B", pe_floatB, 0);
    chk("clr_rdy", in_ready, 0);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk("feed_A", pe_floatA, wp[k*DW +: DW]);
      chk("feed_B", pe_floatB, kp[k*DW +: DW]);
      chk("feed_clr", pe_clear, 0);
      chk("feed_vld", out_valid, 0);
      chk("feed_rdy", in_ready, 0);
      start     = 1'($urandom);
      out_ready = 1'($urandom);
      if (scramble)
        for (int i = 0; i < N; i++) window[i*DW +: DW] = 16'($urandom);
      if (k == rst_k) begin
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        #1;
        chk_reset_vals("midrst");
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("postrst");
        return;
      end
    end
    @(negedge clk);
    chk("cap_A", pe_floatA, 0);
    chk("cap_B", pe_floatB, 0);
    chk("cap_clr", pe_clear, 0);
    chk("cap_vld", out_valid, 0);
    @(negedge clk);
    chk("done_vld", out_valid, 1);
    chk("done_data", out_data, exp_data);
    chk("done_rdy", in_ready, 0);
    out_ready = (hold == 0);
    start     = 1'($urandom);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_vld", out_valid, 1);
      chk("hold_data", out_data, exp_data);
      chk("hold_rdy", in_ready, 0);
      chk("hold_A", pe_floatA, 0);
      chk("hold_clr", pe_clear, 0);
      start     = 1'($urandom);
      out_ready = (h == hold - 1);
    end
    @(negedge clk);
    chk("ack_vld", out_valid, 0);
    chk("ack_rdy", in_ready, 1);
    start     = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int one[N], two[N], zero[N], wv[N], kv[N];
    int dot, hold, rk;
    bit scr;
    for (int i = 0; i < N; i++) begin one[i] = 1; two[i] = 2; zero[i] = 0; end

    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("idle");

    run_job(one, one, 16'h4880, 0, 1'b0, -1);
    run_job(two, one, 16'h4C80, 0, 1'b0, -1);
    run_job(two, zero, 16'h0000, 0, 1'b0, -1);
    run_job(one, one, 16'h4880, 20, 1'b0, -1);
    run_job(one, one, 16'h4880, 0, 1'b1, -1);
    run_job(one, one, 16'h4880, 0, 1'b0, 4);
    run_job(one, one, 16'h4880, 0, 1'b0, -1);

    repeat (25) begin
      dot = 0;
      for (int i = 0; i < N; i++) begin
        wv[i] = $urandom_range(0, 4);
        kv[i] = $urandom_range(0, 4);
        dot += wv[i] * kv[i];
      end
      hold = $urandom_range(0, 3);
      scr  = 1'($urandom);
      rk   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, N - 1) : -1;
      run_job(wv, kv, to_fp16(dot), hold, scr, rk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
